tcb_sub_mem: RTL

TCB_SUB_MEM -- requirements
Module: tcb_sub_mem

---
 rtl/tcb_sub_mem.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tcb_sub_mem.sv
// tcb_sub_mem: TCB subordinate backed by a word-organised memory.
// Accepts one transfer per cycle (optionally throttled by a ready pause),
// flags misaligned and out-of-range accesses, applies byte-masked writes
// and returns responses through a configurable-depth pipeline.
module tcb_sub_mem #(
  parameter int ABW = 32,        // address bus width
  parameter int DBW = 32,        // data bus width
  parameter int SLW = 8,         // selection (byte) width
  parameter int BEW = DBW/SLW,   // byte enable width
  parameter int DLY = 1,         // response delay in clock periods (0..8)
  parameter int SIZ = 256,       // memory depth in words (power of 2)
  parameter int RDP = 0          // ready pause after each transfer (0..15)
) (
  input  logic           clk,
  input  logic           rst,    // asynchronous, active-low
  input  logic           vld,
  input  logic           wen,
  input  logic [ABW-1:0] adr,
  input  logic [BEW-1:0] ben,
  input  logic [DBW-1:0] wdt,
  input  logic           lck,
  input  logic           rpt,
  output logic           rdy,
  output logic           rsp,
  output logic [DBW-1:0] rdt,
  output logic           err
);

  // Byte-offset bits inside a word, memory index bits, pause counter bits.
  localparam int BAW = (BEW > 1) ? $clog2(BEW) : 0;
  localparam int MAW = (SIZ > 1) ? $clog2(SIZ) : 1;
  localparam int CNW = 4;

  localparam logic [ABW-1:0] ALN_MSK = ABW'((64'd1 << BAW) - 64'd1);
  localparam logic [ABW-1:0] SIZ_W   = ABW'(SIZ);
  localparam logic [CNW-1:0] RDP_W   = CNW'(RDP);
  localparam logic [CNW-1:0] CNT_ONE = {{(CNW-1){1'b0}}, 1'b1};

  // Request decode.
  logic           trn_s;
  logic           mis_s;
  logic           oor_s;
  logic           bad_s;
  logic           wr_s;
  logic [ABW-1:0] idx_s;
  logic [MAW-1:0] wad_s;

  // Storage: intentionally not reset.
  logic [DBW-1:0] mem_q [SIZ];

  // Response entering the pipeline this cycle.
  logic           rsp_d;
  logic           err_d;
  logic [DBW-1:0] rdt_d;

  // Ready pause.
  logic [CNW-1:0] cnt_q;
  logic [CNW-1:0] cnt_d;
  logic           rdy_q;
  logic           rdy_d;

  // Arbitration lock and repeat are accepted but carry no meaning here.
  logic           unused_s;
  assign unused_s = ^{lck, rpt};

  // Decode the transfer and classify misaligned / out-of-range addresses.
  always_comb begin
    trn_s = vld & rdy_q;
    idx_s = adr >> BAW;
    mis_s = ((adr & ALN_MSK) != {ABW{1'b0}});
    oor_s = (idx_s >= SIZ_W);
    bad_s = mis_s | oor_s;
    wr_s  = trn_s & wen & ~bad_s;
    wad_s = idx_s[MAW-1:0];
  end

  // Form the response for this cycle's transfer; idle or errored slots carry zero data.
  always_comb begin
    rsp_d = 1'b0;
    err_d = 1'b0;
    rdt_d = {DBW{1'b0}};
    if (trn_s) begin
      rsp_d = 1'b1;
      if (bad_s) begin
        err_d = 1'b1;
      end else if (!wen) begin
        rdt_d = mem_q[wad_s];
      end else begin
        rdt_d = {DBW{1'b0}};
      end
    end else begin
      rsp_d = 1'b0;
    end
  end

  // Byte-masked write at the transfer edge; reads above see the pre-edge word.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      for (int i = 0; i < BEW; i++) begin
        if (ben[i]) begin
          mem_q[wad_s][i*SLW +: SLW] <= wdt[i*SLW +: SLW];
        end
      end
    end
  end

  // Pause counter next state: reload on every transfer, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (trn_s) begin
      cnt_d = RDP_W;
    end else if (cnt_q != {CNW{1'b0}}) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    rdy_d = (cnt_d == {CNW{1'b0}});
  end

  // Pause counter and registered ready; ready stays low while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNW{1'b0}};
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  assign rdy = rdy_q;

  generate
    if (DLY == 0) begin : g_comb
      // Zero delay: the response is visible in the transfer cycle.
      assign rsp = rsp_d;
      assign err = err_d;
      assign rdt = rdt_d;
    end else begin : g_pipe
      logic [DLY-1:0] rsp_q;
      logic [DLY-1:0] err_q;
      logic [DBW-1:0] rdt_q [DLY];

      // Response delay line; reset drops every response still in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rsp_q <= {DLY{1'b0}};
          err_q <= {DLY{1'b0}};
          for (int i = 0; i < DLY; i++) begin
            rdt_q[i] <= {DBW{1'b0}};
          end
        end else begin
          rsp_q[0] <= rsp_d;
          err_q[0] <= err_d;
          rdt_q[0] <= rdt_d;
          for (int i = 1; i < DLY; i++) begin
            rsp_q[i] <= rsp_q[i-1];
            err_q[i] <= err_q[i-1];
            rdt_q[i] <= rdt_q[i-1];
          end
        end
      end

      assign rsp = rsp_q[DLY-1];
      assign err = err_q[DLY-1];
      assign rdt = rdt_q[DLY-1];
    end
  endgenerate

endmodule
